cdb_broadcast: RTL
==================

Name: cdb_broadcast

Overview:
- Common-data-bus writeback stage; the producer side of the wakeup protocol that the reservation stations and dispatch consume.
- Accepts completions from the three functional units (FU0..FU2) into small per-FU buffers and arbitrates them round-robin onto a single result bus.
- Drives ps_in/ps_ready wakeup to the reservation stations and owns the 128-entry physical-register ready table (preg_rtable) read by the reservation stations at dispatch.

Parameters:
NUM_FU, 3, number of completing functional units
BUF_DEPTH, 2, entries per FU result buffer (power of 2)
PREG_W, 7, physical register index width (128 pregs); ps_in carries it zero-extended to 8 bits
ROB_W, 5, ROB index width (32 entries)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fu_valid  in  NUM_FU  FU i presents a completion
fu_pd  in  NUM_FU x 8  destination preg per FU
fu_rob_index  in  NUM_FU x ROB_W  ROB tag per FU
fu_result  in  NUM_FU x 32  result value per FU
fu_accept  out  NUM_FU  buffer i can take a completion this cycle
alloc_valid  in  1  rename allocates a new pd this cycle
alloc_pd  in  8  preg being allocated
mispredict  in  1  branch mispredict flush
mispredict_tag  in  ROB_W  ROB tag of the mispredicted branch
rob_head  in  ROB_W  oldest ROB entry, used for age comparison
ps_in  out  8  broadcast preg
ps_ready  out  1  broadcast valid, single-cycle pulse
cdb_rob_index  out  ROB_W  broadcast ROB tag, for ROB completion marking
cdb_result  out  32  broadcast value, for PRF write
preg_rtable  out  128 x 1  preg ready table

Behaviour:
- Reset (async):
  - All buffers empty; rr_ptr=0.
  - ps_ready=0; ps_in, cdb_rob_index and cdb_result = 0.
  - preg_rtable all 1.
  - fu_accept = all 1 on the first cycle after reset.
- fu_accept[i] is combinational: high iff buffer i is not full. Pop in the same cycle does not free a slot.
- Enqueue: fu_valid[i] & fu_accept[i] at edge k. If fu_pd[i]==0, the completion is accepted and dropped.
- Arbitration, per cycle:
  - Consider the head entries of non-empty buffers, after applying the flush mask.
  - Grant the first one found searching from rr_ptr upward mod NUM_FU.
  - Pop the granted head and set rr_ptr = grant+1 mod NUM_FU.
  - An entry enqueued at edge k is eligible from cycle k+1. Its broadcast registers at edge k+1 at the earliest, so ps_ready is high during cycle k+1..k+2.
- Outputs: registered. ps_ready=1 for exactly one cycle per granted entry; ps_ready=0 if there is no grant, with ps_in/data held.
- preg_rtable updates at the same edge the broadcast registers:
  - Bit ps_in is set.
  - On alloc_valid, bit alloc_pd is cleared.
  - If both target the same preg, the clear wins.
  - Bit 0 is never cleared.
- Mispredict, same cycle:
  - Compute age(x) = (x - rob_head) mod 32.
  - Every buffered entry with age > age(mispredict_tag) is invalidated before arbitration, so it is never broadcast.
  - An FU completion arriving that same cycle with a younger tag is dropped.
  - The entry equal to the tag and older entries are kept.
  - Surviving entries keep FIFO order; buffers compact.
  - preg_rtable is not altered by the flush.
- Full buffers: fu_accept low; FU i must hold its result; no loss.
- Reset mid-operation discards all buffered and in-flight broadcasts immediately.

Decomposition:
- types_pkg gains:
  - cdb_entry_t {valid, pd[7:0], rob_index[4:0], result[31:0]}
  - CDB_NUM_FU, CDB_BUF_DEPTH constants
  - a rob_age() function
- One sub-module: cdb_fu_buffer, a per-FU FIFO with push, pop, flush-by-age and compaction, instantiated NUM_FU times.
- Round-robin arbiter and ready table live in the top.

Test Plan:
- Single completion: FU1 valid with pd=0x25, rob=3, result=0xDEAD at edge 0 -> ps_ready=1, ps_in=0x25, cdb_rob_index=3, cdb_result=0xDEAD after edge 1; preg_rtable[0x25]=1; ps_ready=0 next cycle.
- Fairness: all three FUs valid every cycle for 6 cycles -> grants FU0,FU1,FU2,FU0,FU1,FU2; each fu_accept drops when its buffer holds 2 entries; no entry lost or duplicated.
- Ready table: alloc_pd=0x40 -> bit 0x40=0 next cycle; later broadcast of 0x40 -> 1; alloc and broadcast of 0x41 in the same cycle -> bit stays 0; alloc_pd=0 -> bit 0 stays 1.
- Flush: rob_head=30, buffered tags {31,2,5}, mispredict_tag=1 -> only 31 is broadcast; the entries for 2 and 5 never appear on ps_in.
- Drop x0: FU0 completes with pd=0 -> fu_accept stays high; no ps_ready pulse.
- Reset while buffers hold 4 entries -> ps_ready=0 immediately; all buffers empty; preg_rtable all 1; no stale broadcast after reset release.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the writeback / common-data-bus stage: result-buffer entry
// layout, sizing constants and ROB age arithmetic.
package types_pkg;

  localparam int CDB_NUM_FU    = 3;
  localparam int CDB_BUF_DEPTH = 2;
  localparam int CDB_ROB_W     = 5;

  typedef struct packed {
    logic                 valid;
    logic [7:0]           pd;
    logic [CDB_ROB_W-1:0] rob_index;
    logic [31:0]          result;
  } cdb_entry_t;

  // Distance of a tag from the ROB head; larger means younger.
  function automatic logic [CDB_ROB_W-1:0] rob_age(input logic [CDB_ROB_W-1:0] tag,
                                                   input logic [CDB_ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/cdb_fu_buffer.sv
// Per-FU completion FIFO. Entries stay packed at the low slots; a mispredict
// removes entries younger than the branch and the survivors close up in order.
module cdb_fu_buffer
  import types_pkg::*;
#(
  parameter int DEPTH = CDB_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  cdb_entry_t           push_entry,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [CDB_ROB_W-1:0] flush_age,
  input  logic [CDB_ROB_W-1:0] rob_head,
  output cdb_entry_t           head,
  output logic                 full
);

  cdb_entry_t entries [DEPTH];
  cdb_entry_t kept    [DEPTH];
  cdb_entry_t nxt     [DEPTH];
  logic       push_ok;
  int         n_kept;
  int         n_after;

  // Survivors of the flush are gathered in order, then the popped head is
  // shifted out and the incoming completion lands behind the last survivor.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) kept[j] = '0;
    n_kept = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid &&
          !(flush && (rob_age(entries[i].rob_index, rob_head) > flush_age))) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == n_kept) kept[j] = entries[i];
        end
        n_kept = n_kept + 1;
      end
    end
    push_ok = push && !(flush && (rob_age(push_entry.rob_index, rob_head) > flush_age));
    n_after = (pop && (n_kept > 0)) ? n_kept - 1 : n_kept;
    for (int j = 0; j < DEPTH; j++) begin
      nxt[j] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i == j + (pop ? 1 : 0)) nxt[j] = kept[i];
      end
      if (push_ok && (j == n_after)) nxt[j] = push_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) entries[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) entries[j] <= nxt[j];
    end
  end

  assign head = kept[0];
  assign full = entries[DEPTH-1].valid;

endmodule

// File: rtl/cdb_broadcast.sv
// Common-data-bus writeback: buffers FU completions, arbitrates them round-robin
// onto one registered result bus and maintains the physical-register ready table.
module cdb_broadcast
  import types_pkg::*;
#(
  parameter int NUM_FU    = CDB_NUM_FU,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = CDB_ROB_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][7:0]         fu_pd,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_index,
  input  logic [NUM_FU-1:0][31:0]        fu_result,
  output logic [NUM_FU-1:0]              fu_accept,
  input  logic                           alloc_valid,
  input  logic [7:0]                     alloc_pd,
  input  logic                           mispredict,
  input  logic [ROB_W-1:0]               mispredict_tag,
  input  logic [ROB_W-1:0]               rob_head,
  output logic [7:0]                     ps_in,
  output logic                           ps_ready,
  output logic [ROB_W-1:0]               cdb_rob_index,
  output logic [31:0]                    cdb_result,
  output logic [(1<<PREG_W)-1:0]         preg_rtable
);

  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]      full;
  logic [NUM_FU-1:0]      push;
  logic [NUM_FU-1:0]      pop;
  cdb_entry_t             heads [NUM_FU];
  logic [ROB_W-1:0]       flush_age;
  logic [FU_W-1:0]        rr_ptr;
  logic [FU_W-1:0]        rr_next;
  logic [FU_W-1:0]        grant_idx;
  logic                   grant_found;
  cdb_entry_t             grant_entry;
  logic [(1<<PREG_W)-1:0] rtable_next;

  assign flush_age = rob_age(mispredict_tag, rob_head);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_buf
    cdb_entry_t in_entry;

    // Completions to p0 are acknowledged but never stored.
    assign in_entry     = '{valid: 1'b1, pd: fu_pd[i], rob_index: fu_rob_index[i],
                            result: fu_result[i]};
    assign fu_accept[i] = ~full[i];
    assign push[i]      = fu_valid[i] & ~full[i] & (fu_pd[i] != 8'd0);
    assign pop[i]       = grant_found & (grant_idx == FU_W'(i));

    cdb_fu_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (push[i]),
      .push_entry (in_entry),
      .pop        (pop[i]),
      .flush      (mispredict),
      .flush_age  (flush_age),
      .rob_head   (rob_head),
      .head       (heads[i]),
      .full       (full[i])
    );
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!grant_found && heads[i].valid && (i == (int'(rr_ptr) + off) % NUM_FU)) begin
          grant_found = 1'b1;
          grant_idx   = FU_W'(i);
          grant_entry = heads[i];
        end
      end
    end
    rr_next = FU_W'((int'(grant_idx) + 1) % NUM_FU);
  end

  // An allocation in the same cycle as a broadcast of that preg leaves it not-ready.
  always_comb begin
    rtable_next = preg_rtable;
    if (grant_found && ((grant_entry.pd >> PREG_W) == 8'd0))
      rtable_next[grant_entry.pd[PREG_W-1:0]] = 1'b1;
    if (alloc_valid && (alloc_pd != 8'd0) && ((alloc_pd >> PREG_W) == 8'd0))
      rtable_next[alloc_pd[PREG_W-1:0]] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      ps_ready      <= 1'b0;
      ps_in         <= '0;
      cdb_rob_index <= '0;
      cdb_result    <= '0;
      preg_rtable   <= '1;
    end else begin
      ps_ready    <= grant_entry.valid;
      preg_rtable <= rtable_next;
      if (grant_found) begin
        rr_ptr        <= rr_next;
        ps_in         <= grant_entry.pd;
        cdb_rob_index <= grant_entry.rob_index;
        cdb_result    <= grant_entry.result;
      end
    end
  end

endmodule
